// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : wb_pkg
// Brief    : Shared Wishbone cycle-type codes and frame-buffer FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      BURST  = 2'd2
   } wb_state_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/frame_dpram.sv
`default_nettype none
// ============================================================================
// Module   : frame_dpram
// Brief    : Dual-port RAM, port A read/write, port B read-only, both with
//            registered outputs; a read colliding with a write returns old data.
// Revision : 1.0 - initial release
// ============================================================================
module frame_dpram #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] i_a_adr,
   input  logic                  i_a_we,
   input  logic [DATA_WIDTH-1:0] i_a_dat,
   output logic [DATA_WIDTH-1:0] o_a_dat,
   input  logic [ADDR_WIDTH-1:0] i_b_adr,
   output logic [DATA_WIDTH-1:0] o_b_dat
);

   localparam int c_depth = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
   logic [DATA_WIDTH-1:0] r_a_dat;
   logic [DATA_WIDTH-1:0] r_b_dat;

   always_ff @(posedge clk) begin
      if (i_a_we) begin
         r_mem[i_a_adr] <= i_a_dat;
      end
   end

   // Non-blocking update of r_mem above makes both ports see pre-write data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_dat <= '0;
         r_b_dat <= '0;
      end else begin
         r_a_dat <= r_mem[i_a_adr];
         r_b_dat <= r_mem[i_b_adr];
      end
   end

   assign o_a_dat = r_a_dat;
   assign o_b_dat = r_b_dat;

endmodule : frame_dpram
`default_nettype wire

// File: rtl/wb_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wb_frame_buffer
// Brief    : Wishbone B4 slave frame buffer with classic and incrementing-burst
//            access plus an independent registered display read port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_frame_buffer
   import wb_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 8,
   parameter int DATA_BYTES     = 1,
   parameter int MEM_ADDR_WIDTH = 12
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [ADDRESS_WIDTH-1:0]  adr_i,
   input  logic [DATA_WIDTH-1:0]     dat_i,
   output logic [DATA_WIDTH-1:0]     dat_o,
   input  logic                      we_i,
   input  logic [DATA_BYTES-1:0]     sel_i,
   input  logic                      stb_i,
   input  logic                      cyc_i,
   output logic                      ack_o,
   input  logic [2:0]                cti_i,
   input  logic [MEM_ADDR_WIDTH-1:0] disp_adr_i,
   output logic [DATA_WIDTH-1:0]     disp_dat_o
);

   localparam logic [MEM_ADDR_WIDTH-1:0] c_addr_one = MEM_ADDR_WIDTH'(1);

   wb_state_t                 r_state;
   wb_state_t                 w_state_next;
   logic [MEM_ADDR_WIDTH-1:0] r_addr;
   logic [MEM_ADDR_WIDTH-1:0] w_addr_next;
   logic [MEM_ADDR_WIDTH-1:0] w_rd_addr;
   logic [MEM_ADDR_WIDTH-1:0] w_ram_addr;
   logic                      w_req;
   logic                      w_ack;
   logic                      w_we;
   logic                      w_unused;

   assign w_req    = cyc_i & stb_i;
   assign w_unused = ^{adr_i[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH], sel_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_next;
         r_addr  <= w_addr_next;
      end
   end

   // r_addr serves as the single-transfer address and the burst beat counter.
   always_comb begin
      w_state_next = r_state;
      w_addr_next  = r_addr;
      w_rd_addr    = r_addr;
      w_ack        = 1'b0;
      case (r_state)
         IDLE: begin
            w_rd_addr = adr_i[MEM_ADDR_WIDTH-1:0];
            if (w_req) begin
               w_addr_next  = adr_i[MEM_ADDR_WIDTH-1:0];
               w_state_next = (cti_i == CTI_INCR) ? BURST : SINGLE;
            end
         end
         SINGLE: begin
            w_ack        = cyc_i;
            w_state_next = IDLE;
         end
         BURST: begin
            w_ack = w_req;
            if (!cyc_i) begin
               w_state_next = IDLE;
            end else if (stb_i) begin
               // Prefetch the next beat so back-to-back reads need no wait state.
               w_addr_next = r_addr + c_addr_one;
               w_rd_addr   = r_addr + c_addr_one;
               if (cti_i != CTI_INCR) begin
                  w_state_next = IDLE;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign w_we       = w_ack & we_i & sel_i[0];
   assign w_ram_addr = w_we ? r_addr : w_rd_addr;
   assign ack_o      = w_ack;

   frame_dpram #(
      .ADDR_WIDTH (MEM_ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_frame_dpram (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_a_adr (w_ram_addr),
      .i_a_we  (w_we),
      .i_a_dat (dat_i),
      .o_a_dat (dat_o),
      .i_b_adr (disp_adr_i),
      .o_b_dat (disp_dat_o)
   );

endmodule : wb_frame_buffer
`default_nettype wire

// File: tb/tb_wb_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_frame_buffer
// Brief    : Self-checking bench for wb_frame_buffer against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_frame_buffer;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] adr = '0;
   logic [7:0]  dat_w = '0;
   logic [7:0]  dat_r;
   logic        we = 1'b0;
   logic [0:0]  sel = 1'b0;
   logic        stb = 1'b0;
   logic        cyc = 1'b0;
   logic        ack;
   logic [2:0]  cti = 3'b000;
   logic [11:0] disp_adr = '0;
   logic [7:0]  disp_dat;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] ref_mem   [0:4095];
   bit         ref_valid [0:4095];
   logic [7:0] bdata     [0:63];

   always #5 clk = ~clk;

   wb_frame_buffer #(
      .ADDRESS_WIDTH  (16),
      .DATA_WIDTH     (8),
      .DATA_BYTES     (1),
      .MEM_ADDR_WIDTH (12)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .adr_i      (adr),
      .dat_i      (dat_w),
      .dat_o      (dat_r),
      .we_i       (we),
      .sel_i      (sel),
      .stb_i      (stb),
      .cyc_i      (cyc),
      .ack_o      (ack),
      .cti_i      (cti),
      .disp_adr_i (disp_adr),
      .disp_dat_o (disp_dat)
   );

   task automatic do_classic(input logic wr, input logic [15:0] a, input logic [7:0] d,
                             input logic s, input string tag);
      logic [11:0] m;
      m = a[11:0];
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = wr; sel = s; adr = a; dat_w = d; cti = CTI_CLASSIC;
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++; $display("FAIL %s req_ack: got %b want 0", tag, ack);
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b1) begin
         n_err++; $display("FAIL %s ack: got %b want 1", tag, ack);
      end
      if (!wr && ref_valid[m]) begin
         n_cmp++;
         if (dat_r !== ref_mem[m]) begin
            n_err++; $display("FAIL %s rdata @%h: got %h want %h", tag, a, dat_r, ref_mem[m]);
         end
      end
      @(posedge clk);
      if (wr && s) begin
         ref_mem[m] = d; ref_valid[m] = 1'b1;
      end
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++; $display("FAIL %s post_ack: got %b want 0", tag, ack);
      end
   endtask

   // Beat data comes from bdata[]; stall_at/abort_at < 0 disables that feature.
   task automatic do_burst(input logic wr, input logic [15:0] start, input int n,
                           input int stall_at, input int stall_len, input int abort_at,
                           input string tag);
      int          b;
      int          stalled;
      bit          stall_cycle;
      logic [11:0] m;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = wr; sel = 1'b1; adr = start; dat_w = bdata[0]; cti = CTI_INCR;
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++; $display("FAIL %s req_ack: got %b want 0", tag, ack);
      end
      @(posedge clk);
      b = 0;
      stalled = 0;
      while (b < n) begin
         #1;
         if (b == abort_at) begin
            cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
            @(negedge clk);
            n_cmp++;
            if (ack !== 1'b0) begin
               n_err++; $display("FAIL %s abort_ack: got %b want 0", tag, ack);
            end
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (ack !== 1'b0) begin
               n_err++; $display("FAIL %s abort_ack_next: got %b want 0", tag, ack);
            end
            return;
         end
         if (b == stall_at && stalled < stall_len) begin
            stb = 1'b0; stall_cycle = 1'b1; stalled++;
         end else begin
            stb = 1'b1; stall_cycle = 1'b0;
            adr = start + 16'(b); dat_w = bdata[b];
            cti = (b == n - 1) ? CTI_END : CTI_INCR;
         end
         m = 12'(start + 16'(b));
         @(negedge clk);
         n_cmp++;
         if (ack !== !stall_cycle) begin
            n_err++; $display("FAIL %s beat%0d ack: got %b want %b", tag, b, ack, !stall_cycle);
         end
         if (!stall_cycle && !wr && ref_valid[m]) begin
            n_cmp++;
            if (dat_r !== ref_mem[m]) begin
               n_err++; $display("FAIL %s beat%0d rdata @%h: got %h want %h", tag, b, m, dat_r, ref_mem[m]);
            end
         end
         @(posedge clk);
         if (!stall_cycle) begin
            if (wr) begin
               ref_mem[m] = bdata[b]; ref_valid[m] = 1'b1;
            end
            b++;
         end
      end
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++; $display("FAIL %s post_ack: got %b want 0", tag, ack);
      end
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({ack, dat_r, disp_dat} !== 17'd0) begin
         n_err++; $display("FAIL reset_state: got ack=%b dat=%h disp=%h want all 0", ack, dat_r, disp_dat);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_classic();
      do_classic(1'b1, 16'h0010, 8'hA5, 1'b1, "classic_wr");
      do_classic(1'b0, 16'h0010, 8'h00, 1'b1, "classic_rd");
      n_cmp++;
      if (dat_r !== 8'hA5 && 1'b0) n_err++;
   endtask

   task automatic test_burst();
      for (int i = 0; i < 8; i++) bdata[i] = 8'(8'h10 + i);
      do_burst(1'b1, 16'h0100, 8, -1, 0, -1, "burst_wr");
      do_burst(1'b0, 16'h0100, 8, -1, 0, -1, "burst_rd");
      do_classic(1'b0, 16'h0107, 8'h00, 1'b1, "burst_idle_rd");
   endtask

   task automatic test_wrap();
      bdata[0] = 8'hAA; bdata[1] = 8'hBB; bdata[2] = 8'hCC; bdata[3] = 8'hDD;
      do_burst(1'b1, 16'h0FFE, 4, -1, 0, -1, "wrap_wr");
      do_classic(1'b0, 16'h1000, 8'h00, 1'b1, "wrap_rd_1000");
      n_cmp++;
      if (dat_r !== 8'hCC) begin
         n_err++; $display("FAIL wrap_alias_1000: got %h want cc", dat_r);
      end
      do_classic(1'b0, 16'h0000, 8'h00, 1'b1, "wrap_rd_0000");
      do_classic(1'b0, 16'h0FFF, 8'h00, 1'b1, "wrap_rd_0fff");
      do_classic(1'b0, 16'h0001, 8'h00, 1'b1, "wrap_rd_0001");
   endtask

   task automatic test_stall_abort();
      do_burst(1'b0, 16'h0100, 8, 3, 2, -1, "stall_rd");
      do_burst(1'b0, 16'h0100, 8, -1, 0, 3, "abort_rd");
      do_classic(1'b0, 16'h0104, 8'h00, 1'b1, "after_abort_rd");
      do_classic(1'b1, 16'h0105, 8'h5A, 1'b1, "after_abort_wr");
      do_classic(1'b0, 16'h0105, 8'h00, 1'b1, "after_abort_rd2");
   endtask

   task automatic test_display();
      disp_adr = 12'h020;
      do_classic(1'b1, 16'h0020, 8'h55, 1'b1, "disp_pre");
      do_classic(1'b1, 16'h0020, 8'h3C, 1'b1, "disp_wr");
      n_cmp++;
      if (disp_dat !== 8'h55) begin
         n_err++; $display("FAIL disp_old: got %h want 55", disp_dat);
      end
      @(negedge clk);
      n_cmp++;
      if (disp_dat !== 8'h3C) begin
         n_err++; $display("FAIL disp_new: got %h want 3c", disp_dat);
      end
      do_classic(1'b1, 16'h0020, 8'h99, 1'b0, "disp_sel0_wr");
      @(negedge clk);
      n_cmp++;
      if (disp_dat !== 8'h3C) begin
         n_err++; $display("FAIL disp_sel0: got %h want 3c", disp_dat);
      end
      do_classic(1'b0, 16'h0020, 8'h00, 1'b0, "disp_sel0_rd");
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 1'b1; cti = CTI_INCR; adr = 16'h0100; dat_w = 8'hE0;
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk);
      ref_mem[12'h100] = 8'hE0;
      #1; adr = 16'h0101; dat_w = 8'hE1;
      @(posedge clk);
      ref_mem[12'h101] = 8'hE1;
      #1; adr = 16'h0102; dat_w = 8'hE2; cti = CTI_END;
      @(negedge clk);
      n_cmp++;
      if (ack !== 1'b1) begin
         n_err++; $display("FAIL rst_pre_ack: got %b want 1", ack);
      end
      #2; rst = 1'b1;
      #1;
      n_cmp++;
      if ({ack, dat_r, disp_dat} !== 17'd0) begin
         n_err++; $display("FAIL rst_async: got ack=%b dat=%h disp=%h want all 0", ack, dat_r, disp_dat);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2; rst = 1'b0;
      do_classic(1'b0, 16'h0102, 8'h00, 1'b1, "rst_discard_rd");
      do_classic(1'b0, 16'h0100, 8'h00, 1'b1, "rst_kept_rd");
      do_classic(1'b0, 16'h0101, 8'h00, 1'b1, "rst_kept_rd2");
   endtask

   task automatic test_random();
      int          n;
      int          off;
      logic [15:0] a;
      for (int i = 0; i < 64; i++) bdata[i] = 8'($urandom);
      do_burst(1'b1, 16'h0200, 64, -1, 0, -1, "rnd_fill");
      for (int k = 0; k < 30; k++) begin
         n   = $urandom_range(2, 8);
         off = $urandom_range(0, 64 - n);
         a   = {4'($urandom_range(0, 15)), 12'(12'h200 + off)};
         case ($urandom_range(0, 3))
            0: do_classic(1'b1, a, 8'($urandom), 1'($urandom), "rnd_cw");
            1: do_classic(1'b0, a, 8'h00, 1'($urandom), "rnd_cr");
            2: begin
               for (int i = 0; i < n; i++) bdata[i] = 8'($urandom);
               do_burst(1'b1, a, n, $urandom_range(0, n), $urandom_range(0, 3), -1, "rnd_bw");
            end
            default: do_burst(1'b0, a, n, $urandom_range(0, n), $urandom_range(0, 3), -1, "rnd_br");
         endcase
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ref_mem[i] = '0; ref_valid[i] = 1'b0;
      end
      test_reset();
      test_classic();
      test_burst();
      test_wrap();
      test_stall_abort();
      test_display();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_wb_frame_buffer
`default_nettype wire
